axi_read_arbiter: RTL
=====================

// Module: axi_read_arbiter
// PURPOSE
//  Parametrised AXI4 read-address/read-data arbiter shared by N cache/uncached requesters
//  (inst, data, future TLB walker / prefetcher) in the MMU. Replaces fixed data-first
//  combinational muxing: registered grant, round-robin or fixed priority, ID-tagged
//  bursts, per-requester handshakes. One outstanding AXI read transaction at a time.
// PARAMETERS
//  N_MASTERS   2   number of requesters (1..8); index 0 highest in fixed-priority mode
//  ADDR_W      32  address width
//  DATA_W      32  data width (arsize fixed = log2(DATA_W/8))
//  LINE_BEATS  16  beats of a cached (non-single) burst; arlen = LINE_BEATS-1
//  ID_W        4   AXI ID width; must satisfy 2**ID_W >= N_MASTERS
//  RR_MODE     1   1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//  clk         in   1                  clock, all state on rising edge
//  rst         in   1                  asynchronous, active-low reset
//  m_req       in   N_MASTERS          requester i wants a read; held until m_addr_ok[i]
//  m_addr      in   N_MASTERS*ADDR_W   request addresses, slice i = [i*ADDR_W +: ADDR_W]
//  m_single    in   N_MASTERS          1 = single beat (uncached), 0 = LINE_BEATS burst
//  m_addr_ok   out  N_MASTERS          one-cycle pulse: address accepted by AXI
//  m_rdata     out  DATA_W             read data, shared; valid only with m_rvalid
//  m_rvalid    out  N_MASTERS          beat valid for requester i
//  m_rlast     out  N_MASTERS          last beat for requester i
//  m_rerr      out  N_MASTERS          beat carries SLVERR/DECERR (rresp[1]==1)
//  arid/araddr/arlen/arsize/arburst/arvalid  out  AXI AR channel
//  arready     in   1                  AXI AR ready
//  rid/rdata/rresp/rlast/rvalid  in    AXI R channel
//  rready      out  1                  AXI R ready
// BEHAVIOUR
//  Reset (rst==0, immediate): state IDLE, grant=0, rr_ptr=0, beat_cnt=0; arvalid,
//   rready, m_addr_ok, m_rvalid, m_rlast, m_rerr all 0; araddr/arlen/arburst/arid 0.
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if |m_req, select winner: RR_MODE=1 first set bit searching from rr_ptr
//   upward with wrap; RR_MODE=0 lowest set index. Latch grant, araddr=m_addr[g],
//   arlen=m_single[g]?0:LINE_BEATS-1, arburst=m_single[g]?2'b00:2'b01, arid=g. -> ADDR.
//  ADDR: arvalid=1 with all AR fields stable (registered). On arvalid&&arready:
//   m_addr_ok[g]=1 for that cycle only, beat_cnt=0, -> DATA. Dropping m_req[g] in
//   ADDR does not retract arvalid; transaction completes and data is still delivered.
//  DATA: rready=1. Beat with rvalid&&rid==arid: m_rdata=rdata, m_rvalid[g]=1,
//   m_rlast[g]=rlast, m_rerr[g]=rresp[1]; combinational pass-through, 0-cycle latency;
//   beat_cnt increments (width clog2(LINE_BEATS)+1). Beats with rid!=arid accepted
//   and dropped. On accepted rlast: -> IDLE, rr_ptr=(g+1) mod N_MASTERS.
//  Protocol error: rlast before expected count, or beat_cnt reaching expected without
//   rlast -> m_rerr[g]=1 on that beat; transaction still ends only on rlast.
//  Latency: m_req rising in IDLE -> arvalid next cycle; one IDLE bubble between bursts.
//  Non-granted m_* outputs always 0; at most one m_rvalid bit set per cycle.
//  Simultaneous requests in IDLE: exactly one granted; losers keep m_req asserted.
//  arsize constant; arlock/arcache/arprot tied 0 outside this block.
// TESTING
//  1 Reset: drive rst=0 mid-DATA burst -> all outputs 0 same cycle; after release
//    m_req[1]=1 -> arvalid at next edge with arid=1, state recovers cleanly.
//  2 Burst: m_req[0]=1, m_single=0, addr 0x1FC0_0000, arready 2 cycles late ->
//    arlen=15, arburst=01, one m_addr_ok[0] pulse, 16 m_rvalid[0], m_rlast on 16th.
//  3 RR fairness: m_req=2'b11 held, 4 single reads -> grants 0,1,0,1; RR_MODE=0 ->
//    grants 0,0,0,0 while req[0] stays high.
//  4 Single + error: m_single[1]=1, rresp=2'b10 -> arlen=0, arburst=00,
//    m_rvalid[1]&m_rlast[1]&m_rerr[1] in one cycle, back to IDLE.
//  5 Stray/early: beat with rid=3 during arid=0 -> dropped, no m_rvalid; rlast on
//    beat 8 of 16 -> m_rerr[0]=1 on that beat, FSM to IDLE.
//  6 Retract: m_req[0] deasserted while in ADDR -> arvalid stays 1 until arready,
//    full burst still delivered on m_rvalid[0].

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Shared AXI4 read arbiter: N requesters funnel into one AR/R port, one
// outstanding read transaction at a time, registered grant.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   m_req/m_addr/m_single   per-requester read requests (held until m_addr_ok)
//   m_addr_ok       one-cycle pulse when the granted address is accepted
//   m_rdata/m_rvalid/m_rlast/m_rerr  read beats steered to the granted requester
//   ar*             AXI read-address channel (registered fields)
//   r*              AXI read-data channel
module axi_read_arbiter #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_BEATS = 16,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_single,
  output logic [N_MASTERS-1:0]          m_addr_ok,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_rvalid,
  output logic [N_MASTERS-1:0]          m_rlast,
  output logic [N_MASTERS-1:0]          m_rerr,
  output logic [ID_W-1:0]               arid,
  output logic [ADDR_W-1:0]             araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [ID_W-1:0]               rid,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  localparam int unsigned GW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CW   = $clog2(LINE_BEATS) + 1;
  localparam int unsigned SIZE = $clog2(DATA_W / 8);
  localparam logic [7:0]    LINE_LEN    = 8'(LINE_BEATS - 1);
  localparam logic [CW-1:0] LINE_LAST   = CW'(LINE_BEATS - 1);
  localparam logic [GW-1:0] LAST_MASTER = GW'(N_MASTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     win;
  logic              found;
  int unsigned       idx;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]     last_idx;
  logic [ADDR_W-1:0] araddr_d;
  logic [7:0]        arlen_d;
  logic [1:0]        arburst_d;
  logic [ID_W-1:0]   arid_d;
  logic              hit;
  logic              proto_err;
  logic              unused_rresp;

  // rresp[0] only distinguishes EXOKAY from OKAY; not reported upstream
  assign unused_rresp = rresp[0];

  assign arsize  = 3'(SIZE);
  assign arvalid = (state_q == S_ADDR);
  assign rready  = (state_q == S_DATA);

  // Winner search: round-robin starts at rr_ptr and wraps, fixed starts at 0
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = (RR_MODE != 0) ? (32'(rr_ptr_q) + k) % N_MASTERS : k;
      if (!found && m_req[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  // Index of the beat that must carry rlast for the current transaction
  assign last_idx = (arlen == 8'd0) ? '0 : LINE_LAST;

  // Next-state, AR field capture and beat steering
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    araddr_d   = araddr;
    arlen_d    = arlen;
    arburst_d  = arburst;
    arid_d     = arid;
    m_addr_ok  = '0;
    m_rdata    = '0;
    m_rvalid   = '0;
    m_rlast    = '0;
    m_rerr     = '0;
    hit        = 1'b0;
    proto_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d   = win;
          araddr_d  = m_addr[32'(win) * ADDR_W +: ADDR_W];
          arlen_d   = m_single[win] ? 8'd0 : LINE_LEN;
          arburst_d = m_single[win] ? 2'b00 : 2'b01;
          arid_d    = ID_W'(win);
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        if (arready) begin
          m_addr_ok[grant_q] = 1'b1;
          beat_cnt_d         = '0;
          state_d            = S_DATA;
        end
      end

      S_DATA: begin
        // Beats tagged with another ID are accepted (rready high) and dropped
        hit = rvalid && (rid == arid);
        if (hit) begin
          // rlast must coincide exactly with the expected final beat
          proto_err          = rlast != (beat_cnt_q >= last_idx);
          m_rdata            = rdata;
          m_rvalid[grant_q]  = 1'b1;
          m_rlast[grant_q]   = rlast;
          m_rerr[grant_q]    = rresp[1] | proto_err;
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CW'(1);
          if (rlast) begin
            state_d  = S_IDLE;
            rr_ptr_d = (grant_q == LAST_MASTER) ? '0 : grant_q + GW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and AR field registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      araddr     <= '0;
      arlen      <= '0;
      arburst    <= '0;
      arid       <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      araddr     <= araddr_d;
      arlen      <= arlen_d;
      arburst    <= arburst_d;
      arid       <= arid_d;
    end
  end

endmodule
